imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for all RV32I/RV64I immediate formats: I, S, B, U and J.
- Sits between fetch/decode and the execute operand mux in the pipelined CPU.
- Decodes the instruction word, sign-extends to XLEN, and tags the format.
- Output side has a 2-entry skid buffer, so upstream ready does not combinationally depend on downstream ready.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- BJ_SCALED, 1: B/J immediates include the implicit bit0 = 0 (byte offset). 0: raw halfword offset, unshifted.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  synchronous clear of all buffered entries.
- in_valid_i  input  1  instr_i is valid.
- in_ready_o  output  1  block can accept an instruction.
- instr_i  input  32  instruction word.
- out_valid_o  output  1  imm_o and fmt_o are valid.
- out_ready_i  input  1  downstream consumes the output.
- imm_o  output  XLEN  sign-extended immediate.
- fmt_o  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.

Behaviour:
- Reset (rst_i high, asynchronous): state EMPTY; out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0. Reset asserted mid-operation discards both entries immediately.
- Decode by opcode instr_i[6:0]:
  - I format: 0010011, 0000011, 1100111, 0011011. Immediate is instr[31:20].
  - S format: 0100011. Immediate is {instr[31:25], instr[11:7]}.
  - B format: 1100011. Immediate is {instr[31], instr[7], instr[30:25], instr[11:8]}, plus a trailing 0 when BJ_SCALED=1.
  - U format: 0110111, 0010111. Immediate is {instr[31:12], 12'b0}.
  - J format: 1101111. Immediate is {instr[31], instr[19:12], instr[20], instr[30:21]}, plus a trailing 0 when BJ_SCALED=1.
  - All formats: sign bit is instr[31], replicated up to XLEN.
  - Any other opcode: imm=0, fmt=NONE; the entry is still passed through.
- Handshake:
  - Accept when in_valid_i && in_ready_o.
  - Transfer out when out_valid_o && out_ready_i.
  - Latency: accepted word appears at imm_o one cycle later when the buffer is empty.
  - Throughput: 1 per cycle under continuous out_ready_i.
- States:
  - EMPTY: out_valid_o=0, in_ready_o=1. Accept goes to ONE.
  - ONE (main register valid): out_valid_o=1, in_ready_o=1.
    - Accept and transfer: main reloads, stay ONE.
    - Accept, no transfer: new word goes to skid, go TWO.
    - Transfer, no accept: go EMPTY.
  - TWO (main + skid valid): in_ready_o=0.
    - Transfer: skid moves to main, go ONE.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Output stability: imm_o and fmt_o stay stable while out_valid_o && !out_ready_i.
- flush_i: next state EMPTY, overriding any same-cycle accept and transfer. In the flush cycle in_ready_o keeps its state-based value, but the word is dropped.
- Registers not covered by reset hold 0 after reset; only imm/fmt/valid need reset.

Optional Feature:
- Macro IMM_GEN_ILLEGAL_EN.
- Defined: adds output port illegal_o (1 bit, registered, travels with its entry, reset 0).
  - illegal_o=1 when the opcode is not any of: the recognised immediate opcodes, 0110011, 0111011 (R-type), 0001111, 1110011.
  - illegal_o=1 also when instr_i[1:0] != 2'b11.
- Undefined: port absent; unknown opcodes give fmt NONE and imm 0 silently.

Decomposition:
- Package imm_gen_pkg:
  - Opcode localparams.
  - Format enum constants (FMT_NONE..FMT_J, 3 bits).
  - State encoding (EMPTY/ONE/TWO).
- Sub-module imm_decode: purely combinational.
  - Inputs: instr.
  - Outputs: imm[XLEN], fmt, and illegal when enabled.
  - Parameterised by XLEN and BJ_SCALED.
- imm_gen_pipe instantiates imm_decode once, on the input side, and owns the skid/handshake logic.

Test Plan:
- XLEN=64, out_ready_i=1: 0xFFF00093 (addi -1) -> next cycle imm_o=0xFFFFFFFFFFFFFFFF, fmt_o=1.
- Same configuration: 0xFE113C23 (sd -8) -> imm_o=0xFFFFFFFFFFFFFFF8, fmt_o=2.
- Same configuration: 0xFE000EE3 (beq -4) -> imm_o=0xFFFFFFFFFFFFFFFC, fmt_o=3. With BJ_SCALED=0 -> 0xFFFFFFFFFFFFFFFE.
- U/J: 0x123450B7 -> imm_o=0x0000000012345000, fmt_o=4. 0x800000B7 -> imm_o=0xFFFFFFFF80000000. 0x0080006F (jal +8) -> imm_o=8, fmt_o=5.
- Backpressure: out_ready_i=0, drive 3 back-to-back valid words (A, B, C).
  - in_ready_o falls after B is accepted; C is held.
  - Raise out_ready_i -> A, B, C emerge on consecutive cycles, in order.
- Reset/flush: hold 2 entries, assert rst_i mid-cycle -> out_valid_o=0 immediately. Repeat with flush_i -> out_valid_o=0 next edge, in_ready_o=1, no stale output afterwards. With IMM_GEN_ILLEGAL_EN: 0x00000000 -> illegal_o=1.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// ------------------------------------------------------------------
// imm_gen_pkg : opcodes, format codes and state encoding.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package imm_gen_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ------------------------------------------------------------------
// imm_decode : combinational RV32I/RV64I immediate decoder.
// Optional: IMM_GEN_ILLEGAL_EN adds illegal_o.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BJ_SCALED = 1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal_o
`endif
);

  logic [31:0] w_imm32;
  logic        w_s;

  assign w_s = instr_i[31];

  always_comb begin
    w_imm32 = '0;
    fmt_o   = FMT_NONE;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: begin
        w_imm32 = {{20{w_s}}, instr_i[31:20]};
        fmt_o   = FMT_I;
      end
      OP_STORE: begin
        w_imm32 = {{20{w_s}}, instr_i[31:25], instr_i[11:7]};
        fmt_o   = FMT_S;
      end
      OP_BRANCH: begin
        if (BJ_SCALED != 0)
          w_imm32 = {{19{w_s}}, w_s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        else
          w_imm32 = {{20{w_s}}, w_s, instr_i[7], instr_i[30:25], instr_i[11:8]};
        fmt_o = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32 = {instr_i[31:12], 12'b0};
        fmt_o   = FMT_U;
      end
      OP_JAL: begin
        if (BJ_SCALED != 0)
          w_imm32 = {{11{w_s}}, w_s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        else
          w_imm32 = {{12{w_s}}, w_s, instr_i[19:12], instr_i[20], instr_i[30:21]};
        fmt_o = FMT_J;
      end
      default: begin
        w_imm32 = '0;
        fmt_o   = FMT_NONE;
      end
    endcase
  end

  // Every format fits in 32 bits; only wider XLEN needs further extension.
  if (XLEN > 32) begin : g_sext
    assign imm_o = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end else begin : g_nosext
    assign imm_o = w_imm32[XLEN-1:0];
  end

`ifdef IMM_GEN_ILLEGAL_EN
  logic w_known;

  always_comb begin
    w_known = 1'b0;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP32, OP_FENCE, OP_SYSTEM:
        w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  assign illegal_o = !w_known || (instr_i[1:0] != 2'b11);
`endif

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ------------------------------------------------------------------
// imm_gen_pipe : registered immediate generator with 2-entry skid buffer.
// Optional: IMM_GEN_ILLEGAL_EN adds illegal_o.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BJ_SCALED = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal_o
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [2:0]      main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_accept, w_xfer;
  logic            w_load_main_dec, w_load_main_skid, w_load_skid;

`ifdef IMM_GEN_ILLEGAL_EN
  logic w_dec_ill;
  logic main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
`endif

  imm_decode #(
    .XLEN      (XLEN),
    .BJ_SCALED (BJ_SCALED)
  ) u_decode (
    .instr_i   (instr_i),
    .imm_o     (w_dec_imm),
    .fmt_o     (w_dec_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_o (w_dec_ill)
`endif
  );

  // Ready depends only on local state, never on out_ready_i.
  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign imm_o       = main_imm_q;
  assign fmt_o       = main_fmt_q;

  assign w_accept = in_valid_i && in_ready_o;
  assign w_xfer   = out_valid_o && out_ready_i;

  assign w_load_main_dec  = !flush_i && w_accept &&
                            ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && w_xfer));
  assign w_load_skid      = !flush_i && w_accept && (state_q == ST_ONE) && !w_xfer;
  assign w_load_main_skid = !flush_i && (state_q == ST_TWO) && w_xfer;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (w_accept) state_d = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_xfer)      state_d = ST_TWO;
          else if (!w_accept && w_xfer) state_d = ST_EMPTY;
        end
        ST_TWO:   if (w_xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    if (flush_i) begin
      main_imm_d = '0;
      main_fmt_d = FMT_NONE;
    end else if (w_load_main_dec) begin
      main_imm_d = w_dec_imm;
      main_fmt_d = w_dec_fmt;
    end else if (w_load_main_skid) begin
      main_imm_d = skid_imm_q;
      main_fmt_d = skid_fmt_q;
    end
    if (w_load_skid) begin
      skid_imm_d = w_dec_imm;
      skid_fmt_d = w_dec_fmt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
    end else begin
      state_q    <= state_d;
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
    end
  end

`ifdef IMM_GEN_ILLEGAL_EN
  always_comb begin
    main_ill_d = main_ill_q;
    skid_ill_d = skid_ill_q;
    if (flush_i)               main_ill_d = 1'b0;
    else if (w_load_main_dec)  main_ill_d = w_dec_ill;
    else if (w_load_main_skid) main_ill_d = skid_ill_q;
    if (w_load_skid)           skid_ill_d = w_dec_ill;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ill_q <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      main_ill_q <= main_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign illegal_o = main_ill_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ------------------------------------------------------------------
// tb_imm_gen_pipe : directed self-checking bench for imm_gen_pipe.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic [31:0] instr_i;

  logic        in_ready_o, out_valid_o;
  logic [63:0] imm_o;
  logic [2:0]  fmt_o;
  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        illegal_o, illegal32;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  imm_gen_pipe #(.XLEN(64), .BJ_SCALED(1)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .imm_o       (imm_o),
    .fmt_o       (fmt_o)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_o   (illegal_o)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .BJ_SCALED(0)) u_dut32 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready32),
    .instr_i     (instr_i),
    .out_valid_o (out_valid32),
    .out_ready_i (out_ready_i),
    .imm_o       (imm32),
    .fmt_o       (fmt32)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_o   (illegal32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; instr_i = '0; out_ready_i = 1'b1;
    tick();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_imm",   imm_o, 0);
    chk("rst_fmt",   fmt_o, 0);
    chk("rst_valid32", out_valid32, 0);
    rst_i = 1'b0;
    tick();
    chk("idle_valid", out_valid_o, 0);

    // Continuous stream with out_ready high: one result per cycle.
    in_valid_i = 1'b1; instr_i = 32'hFFF00093;
    tick();
    chk("addi_valid", out_valid_o, 1);
    chk("addi_imm",   imm_o, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_fmt",   fmt_o, 1);
    chk("addi_imm32", imm32, 64'h00000000FFFFFFFF);
    instr_i = 32'hFE113C23;
    tick();
    chk("sd_imm",   imm_o, 64'hFFFFFFFFFFFFFFF8);
    chk("sd_fmt",   fmt_o, 2);
    chk("sd_ready", in_ready_o, 1);
    instr_i = 32'hFE000EE3;
    tick();
    chk("beq_imm",   imm_o, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_fmt",   fmt_o, 3);
    chk("beq_imm32_raw", imm32, 64'h00000000FFFFFFFE);
    instr_i = 32'h123450B7;
    tick();
    chk("lui_imm",   imm_o, 64'h0000000012345000);
    chk("lui_fmt",   fmt_o, 4);
    chk("lui_imm32", imm32, 64'h0000000012345000);
    instr_i = 32'h800000B7;
    tick();
    chk("luineg_imm",   imm_o, 64'hFFFFFFFF80000000);
    chk("luineg_imm32", imm32, 64'h0000000080000000);
    instr_i = 32'h0080006F;
    tick();
    chk("jal_imm",   imm_o, 64'd8);
    chk("jal_fmt",   fmt_o, 5);
    chk("jal_imm32_raw", imm32, 64'd4);
    chk("jal_fmt32", fmt32, 5);
    instr_i = 32'h00000033;
    tick();
    chk("rtype_valid", out_valid_o, 1);
    chk("rtype_imm",   imm_o, 0);
    chk("rtype_fmt",   fmt_o, 0);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("rtype_ill", illegal_o, 0);
`endif
    instr_i = 32'h00000000;
    tick();
    chk("zero_imm", imm_o, 0);
    chk("zero_fmt", fmt_o, 0);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("zero_ill",   illegal_o, 1);
    chk("zero_ill32", illegal32, 1);
`endif
    in_valid_i = 1'b0;
    tick();
    chk("drain_valid", out_valid_o, 0);

    // Backpressure: A, B, C offered while downstream stalls.
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h00500093;
    tick();
    chk("bp_a_imm",   imm_o, 64'd5);
    chk("bp_a_ready", in_ready_o, 1);
    instr_i = 32'h123450B7;
    tick();
    chk("bp_b_ready", in_ready_o, 0);
    chk("bp_b_hold",  imm_o, 64'd5);
    instr_i = 32'h0080006F;
    tick();
    chk("bp_c_ready", in_ready_o, 0);
    chk("bp_c_hold",  imm_o, 64'd5);
    chk("bp_c_fmt",   fmt_o, 1);
    out_ready_i = 1'b1;
    tick();
    chk("bp_out_b",   imm_o, 64'h0000000012345000);
    chk("bp_out_bf",  fmt_o, 4);
    chk("bp_ready1",  in_ready_o, 1);
    tick();
    chk("bp_out_c",   imm_o, 64'd8);
    chk("bp_out_cf",  fmt_o, 5);
    in_valid_i = 1'b0;
    tick();
    chk("bp_empty", out_valid_o, 0);

    // Asynchronous reset while two entries are held.
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h00500093;
    tick();
    instr_i = 32'h123450B7;
    tick();
    chk("ar_full", in_ready_o, 0);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_ready", in_ready_o, 1);
    chk("ar_imm",   imm_o, 0);
    #1 rst_i = 1'b0;
    tick();
    chk("ar_after", out_valid_o, 0);

    // Flush while full, with a same-cycle offer and out_ready high.
    in_valid_i = 1'b1; instr_i = 32'h00500093;
    tick();
    instr_i = 32'h123450B7;
    tick();
    flush_i = 1'b1; instr_i = 32'hFFF00093; out_ready_i = 1'b1;
    chk("fl_ready_before", in_ready_o, 0);
    tick();
    chk("fl_valid", out_valid_o, 0);
    chk("fl_ready", in_ready_o, 1);
    flush_i = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("fl_nostale", out_valid_o, 0);
    in_valid_i = 1'b1; instr_i = 32'h0080006F;
    tick();
    chk("fl_new_imm", imm_o, 64'd8);
    // Flush in ONE with an accepted word: the word is dropped.
    flush_i = 1'b1; instr_i = 32'hFFF00093;
    chk("fl1_ready", in_ready_o, 1);
    tick();
    chk("fl1_valid", out_valid_o, 0);
    flush_i = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("fl1_after", out_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
